calc_op_scheduler: RTL

Sequencer for the calculator arithmetic path. It accepts one signed 4-bit operation request at a time and runs it to completion:
- add and sub in one execute cycle;
- mul as a 4-step shift-add;
- div as a 4-step restoring divide.

It handles sign-magnitude conversion before and after the execute phase and returns an 8-bit signed result with a one-cycle done pulse. It sits between the keypad/PicoVersat command logic and the display-select path.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/calc_muldiv_core.sv | 67 ++++++
 rtl/calc_op_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_pkg                                                           |
// | Shared widths, op codes, FSM states and helpers for the calc path. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package calc_pkg;

    localparam int OPW  = 4;
    localparam int RESW = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ABS  = 3'd1,
        ST_EXEC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Magnitude as unsigned; -8 maps to 4'b1000, which fits unsigned.
    function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] v);
        return v[OPW-1] ? (~v + OPW'(1)) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_muldiv_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_muldiv_core                                                   |
// | Iterative unsigned 4x4 shift-add multiply / restoring divide.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module calc_muldiv_core
    import calc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            step,
    input  logic            mode_div,
    input  logic [OPW-1:0]  mag_a,
    input  logic [OPW-1:0]  mag_b,
    output logic [RESW-1:0] value,
    output logic            last_step
);

    logic [1:0]      r_cnt;
    logic [RESW-1:0] r_acc;
    logic [OPW-1:0]  r_rem;
    logic [OPW-1:0]  r_quo;

    logic [1:0]      w_bit_idx;
    logic [OPW:0]    w_rem_shift;
    logic [OPW:0]    w_divisor;
    logic [RESW-1:0] w_addend;

    // Divide walks the dividend MSB first; multiply walks the multiplier LSB first.
    assign w_bit_idx   = 2'd3 - r_cnt;
    assign w_rem_shift = {r_rem, mag_a[w_bit_idx]};
    assign w_divisor   = {1'b0, mag_b};
    assign w_addend    = mag_b[r_cnt] ? (RESW'(mag_a) << r_cnt) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_quo <= '0;
        end else if (clear) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_quo <= '0;
        end else if (step) begin
            r_cnt <= r_cnt + 2'd1;
            if (mode_div) begin
                if (w_rem_shift >= w_divisor) begin
                    r_rem            <= OPW'(w_rem_shift - w_divisor);
                    r_quo[w_bit_idx] <= 1'b1;
                end else begin
                    r_rem <= w_rem_shift[OPW-1:0];
                end
            end else begin
                r_acc <= r_acc + w_addend;
            end
        end
    end

    assign value     = mode_div ? RESW'(r_quo) : r_acc;
    assign last_step = (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/calc_op_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_op_scheduler                                                  |
// | Sequences one signed 4-bit add/sub/mul/div to an 8-bit result.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module calc_op_scheduler
    import calc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    output logic            busy,
    output logic            done,
    output logic [RESW-1:0] result,
    output logic            error
);

    state_t          r_state;
    logic [1:0]      r_op;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [OPW-1:0]  r_mag_a;
    logic [OPW-1:0]  r_mag_b;
    logic            r_neg;
    logic [RESW-1:0] r_sum;

    logic            w_is_md;
    logic            w_clear;
    logic            w_step;
    logic            w_last;
    logic [RESW-1:0] w_core_val;
    logic [RESW-1:0] w_value;
    logic [RESW-1:0] w_ext_a;
    logic [RESW-1:0] w_ext_b;

    assign w_is_md = r_op[1];
    assign w_clear = (r_state == ST_ABS);
    assign w_step  = (r_state == ST_EXEC) && w_is_md;
    assign w_ext_a = {{(RESW-OPW){r_a[OPW-1]}}, r_a};
    assign w_ext_b = {{(RESW-OPW){r_b[OPW-1]}}, r_b};
    assign w_value = w_is_md ? w_core_val : r_sum;

    calc_muldiv_core u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .step      (w_step),
        .mode_div  (r_op == OP_DIV),
        .mag_a     (r_mag_a),
        .mag_b     (r_mag_b),
        .value     (w_core_val),
        .last_step (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
            r_sum   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        error   <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    r_mag_a <= mag(r_a);
                    r_mag_b <= mag(r_b);
                    r_neg   <= r_a[OPW-1] ^ r_b[OPW-1];
                    // Divide-by-zero skips execute and fix entirely.
                    if ((r_op == OP_DIV) && (r_b == '0)) begin
                        result  <= '0;
                        error   <= 1'b1;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!w_is_md) begin
                        r_sum   <= (r_op == OP_SUB) ? (w_ext_a - w_ext_b) : (w_ext_a + w_ext_b);
                        r_neg   <= 1'b0;
                        r_state <= ST_FIX;
                    end else if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result  <= r_neg ? (RESW'(0) - w_value) : w_value;
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
